classify_arbiter: RTL and testbench
===================================

# classify_arbiter

Shares one `classify` instance between NCH qubit readout channels. Each channel posts I/Q samples into a 1-deep holding buffer. A round-robin scheduler issues one sample at a time to the classifier and presents that channel's discrimination line (point plus perpendicular vector) from a per-channel config bank. It then waits for `valid_output` with a timeout, returns the tagged result, and keeps per-channel shot and excited-state tallies. It sits between the ADC/demodulation front end and the histogram/readout logic.

## Interface
- NCH, 4: number of channels (2..8)
- TIMEOUT, 64: max cycles in WAIT before abort (≥2)
- CW, 16: tally counter width
- clk100  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ch_valid  in  NCH  per-channel sample strobe
- ch_i, ch_q  in  NCH*32  packed signed I/Q samples; channel k occupies bits [32k+31:32k]
- cfg_we  in  1  config write strobe
- cfg_ch  in  3  target channel
- cfg_sel  in  2  target field: 0 i_pt_line, 1 q_pt_line, 2 i_vec_perp, 3 q_vec_perp
- cfg_data  in  32  signed write value
- clr  in  1  synchronous clear of tallies and overflow flags
- cls_data_in  out  1  one-cycle issue strobe to classify
- cls_i_val, cls_q_val, cls_i_pt_line, cls_q_pt_line, cls_i_vec_perp, cls_q_vec_perp  out  32 each  signed classifier operands
- cls_state  in  2  classifier result
- cls_valid  in  1  classifier result strobe
- res_valid  out  1  one-cycle result strobe
- res_ch  out  3  channel of result
- res_state  out  2  classified state (0 on timeout)
- res_timeout  out  1  result aborted by timeout
- busy  out  1  FSM not in IDLE
- ch_overflow  out  NCH  sticky dropped-sample flags
- shot_count, one_count  out  NCH*CW  per-channel count of completed shots and of shots with res_state==1

## Operation
- Buffers:
  - ch_valid[k] with buffer k empty: capture ch_i/ch_q slice, mark full.
  - ch_valid[k] with buffer full and k not granted this cycle: drop sample, set ch_overflow[k].
  - ch_valid[k] on the cycle k is granted: capture new sample, buffer stays full, no overflow.
- Config bank: NCH×4 signed 32-bit registers, written on cfg_we. cfg_ch ≥ NCH is ignored. A write takes effect for any issue starting the next cycle or later. A write to the channel currently in flight does not alter the held cls_* operands.
- FSM: IDLE → ISSUE → WAIT → IDLE.
  - IDLE: if any buffer is full, grant the first full channel searching from last_grant+1 modulo NCH. Copy its sample and config into the issue registers, clear its buffer, go to ISSUE.
  - ISSUE: cls_data_in=1 for exactly this cycle; go to WAIT, wait counter = 0.
  - WAIT: on cls_valid, register res_* with res_timeout=0 and go to IDLE. Otherwise increment the counter; at count TIMEOUT-1 without cls_valid, register the result with res_timeout=1, res_state=0, and go to IDLE.
- cls_valid outside WAIT is ignored.
- cls_* operands are held constant from ISSUE until the next grant.
- Tallies are updated with res_valid:
  - shot_count[res_ch] increments on non-timeout results.
  - one_count[res_ch] increments when res_state==1.
  - Both saturate at 2^CW-1.
  - clr zeroes tallies and ch_overflow; if clr coincides with an increment, clr wins.
- last_grant resets to NCH-1, so channel 0 has first priority.

## Timing
- Reset values: all outputs 0, FSM IDLE, buffers empty, config bank 0, last_grant NCH-1.
- Sample capture: ch_valid at edge t sets the buffer full at t. The grant occurs at edge t+1 if IDLE, ISSUE is cycle t+1..t+2, and cls_data_in is high for the cycle after edge t+1.
- If cls_valid is sampled at edge w in WAIT, res_valid is high for the cycle after edge w and the FSM is IDLE in that same cycle. A new grant can happen at edge w+1.
- Minimum issue interval: L+2 cycles, where L is the classifier latency from the data_in edge to the cls_valid edge.
- Reset asserted mid-transaction aborts immediately: no res_valid, and a late cls_valid after reset release is ignored because the FSM is IDLE.

## Test plan
- Single shot: config ch0 = line (0,2), vector (0,1); ch_valid[0] with I=-3, Q=-3 → exactly one cls_data_in pulse with operands -3,-3,0,2,0,1; result has res_ch=0 and res_state equal to the classifier output; shot_count[0]=1.
- Round robin: all 4 channels strobed on the same cycle → results come out in channel order 0,1,2,3; a second burst after a ch2-only grant order starts from ch3.
- Overflow: ch_valid[1] twice while a ch0 transaction is in WAIT → ch_overflow[1]=1 and one ch1 shot; the second sample is kept only if strobed on ch1's grant cycle.
- Timeout: stub classify never asserts cls_valid, TIMEOUT=64 → res_valid 64 cycles after ISSUE with res_timeout=1 and res_state=0; shot_count unchanged.
- Saturation and clear: CW=4, 20 shots with state 1 → one_count=15; clr on the same cycle as a res_valid → 0.
- Reset mid-WAIT: assert rst_n low, then the stub asserts cls_valid → no res_valid, busy=0, all tallies 0.

Source files
------------

// File: rtl/classify_arbiter.sv
// Round-robin scheduler sharing one classifier between NCH readout channels:
// 1-deep sample buffers, per-channel discrimination-line bank, timeout and tallies.
module classify_arbiter #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic                   clk100,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         ch_valid,
    input  logic [NCH*32-1:0]      ch_i,
    input  logic [NCH*32-1:0]      ch_q,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_ch,
    input  logic [1:0]             cfg_sel,
    input  logic signed [31:0]     cfg_data,
    input  logic                   clr,
    output logic                   cls_data_in,
    output logic signed [31:0]     cls_i_val,
    output logic signed [31:0]     cls_q_val,
    output logic signed [31:0]     cls_i_pt_line,
    output logic signed [31:0]     cls_q_pt_line,
    output logic signed [31:0]     cls_i_vec_perp,
    output logic signed [31:0]     cls_q_vec_perp,
    input  logic [1:0]             cls_state,
    input  logic                   cls_valid,
    output logic                   res_valid,
    output logic [2:0]             res_ch,
    output logic [1:0]             res_state,
    output logic                   res_timeout,
    output logic                   busy,
    output logic [NCH-1:0]         ch_overflow,
    output logic [NCH*CW-1:0]      shot_count,
    output logic [NCH*CW-1:0]      one_count
);
    localparam int IW = $clog2(NCH);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state, next_state;
    logic [NCH-1:0]     buf_full, granted, capture;
    logic signed [31:0] buf_i [NCH];
    logic signed [31:0] buf_q [NCH];
    logic signed [31:0] cfg_bank [NCH][4];
    logic [IW-1:0]      last_grant, gnt_ch, cur_ch, srch;
    logic               gnt_any, do_grant, res_set, res_abort, cfg_ok;
    logic [WW-1:0]      wait_cnt;
    logic [CW-1:0]      shots [NCH];
    logic [CW-1:0]      ones [NCH];

    // First full buffer at or after last_grant+1, wrapping modulo NCH.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = last_grant;
        srch    = '0;
        for (int o = 1; o <= NCH; o++) begin
            srch = IW'((int'(last_grant) + o) % NCH);
            if (!gnt_any && buf_full[srch]) begin
                gnt_any = 1'b1;
                gnt_ch  = srch;
            end
        end
    end

    assign do_grant = (state == S_IDLE) && gnt_any;
    assign granted  = do_grant ? (NCH'(1) << gnt_ch) : '0;
    assign capture  = ch_valid & (~buf_full | granted);
    assign cfg_ok   = ({1'b0, cfg_ch} < 4'(NCH));
    assign busy     = (state != S_IDLE);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        next_state  = state;
        cls_data_in = 1'b0;
        res_set     = 1'b0;
        res_abort   = 1'b0;
        case (state)
            S_IDLE:  if (gnt_any) next_state = S_ISSUE;
            S_ISSUE: begin
                cls_data_in = 1'b1;
                next_state  = S_WAIT;
            end
            S_WAIT: begin
                if (cls_valid) begin
                    res_set    = 1'b1;
                    next_state = S_IDLE;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    res_set    = 1'b1;
                    res_abort  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            buf_full    <= '0;
            ch_overflow <= '0;
        end else begin
            buf_full <= (buf_full & ~granted) | ch_valid;
            if (clr) ch_overflow <= '0;
            else     ch_overflow <= ch_overflow | (ch_valid & buf_full & ~granted);
        end
    end

    // NOTE: sample storage has no reset; buf_full alone says whether a slot holds data.
    always_ff @(posedge clk100) begin
        for (int k = 0; k < NCH; k++) begin
            if (capture[k]) begin
                buf_i[k] <= ch_i[32*k +: 32];
                buf_q[k] <= ch_q[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++)
                for (int f = 0; f < 4; f++) cfg_bank[k][f] <= '0;
        end else if (cfg_we && cfg_ok) begin
            cfg_bank[cfg_ch[IW-1:0]][cfg_sel] <= cfg_data;
        end
    end

    // Operands stay frozen from grant to the next grant, shielding them from config writes.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= IW'(NCH - 1);
            cur_ch         <= '0;
            cls_i_val      <= '0;
            cls_q_val      <= '0;
            cls_i_pt_line  <= '0;
            cls_q_pt_line  <= '0;
            cls_i_vec_perp <= '0;
            cls_q_vec_perp <= '0;
        end else if (do_grant) begin
            last_grant     <= gnt_ch;
            cur_ch         <= gnt_ch;
            cls_i_val      <= buf_i[gnt_ch];
            cls_q_val      <= buf_q[gnt_ch];
            cls_i_pt_line  <= cfg_bank[gnt_ch][0];
            cls_q_pt_line  <= cfg_bank[gnt_ch][1];
            cls_i_vec_perp <= cfg_bank[gnt_ch][2];
            cls_q_vec_perp <= cfg_bank[gnt_ch][3];
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_state   <= '0;
            res_timeout <= 1'b0;
        end else begin
            res_valid <= res_set;
            if (state == S_ISSUE)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (res_set) begin
                res_ch      <= 3'(cur_ch);
                res_state   <= res_abort ? 2'd0 : cls_state;
                res_timeout <= res_abort;
            end
        end
    end

    // Tallies count on the res_valid cycle; clr overrides a coincident increment.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n || clr) begin
            for (int k = 0; k < NCH; k++) begin
                shots[k] <= '0;
                ones[k]  <= '0;
            end
        end else if (res_valid) begin
            for (int k = 0; k < NCH; k++) begin
                if (res_ch == 3'(k)) begin
                    if (!res_timeout && shots[k] != CNT_MAX) shots[k] <= shots[k] + 1'b1;
                    if (res_state == 2'd1 && ones[k] != CNT_MAX) ones[k] <= ones[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        shot_count = '0;
        one_count  = '0;
        for (int k = 0; k < NCH; k++) begin
            shot_count[k*CW +: CW] = shots[k];
            one_count[k*CW +: CW]  = ones[k];
        end
    end

endmodule

// File: tb/tb_classify_arbiter.sv
// Directed bench for classify_arbiter with a fixed-latency classifier stub.
module tb_classify_arbiter;
    localparam int NCH = 4;
    localparam int TIMEOUT = 64;
    localparam int CW = 4;

    logic                   clk100 = 1'b0;
    logic                   rst_n;
    logic [NCH-1:0]         ch_valid;
    logic [NCH*32-1:0]      ch_i, ch_q;
    logic                   cfg_we;
    logic [2:0]             cfg_ch;
    logic [1:0]             cfg_sel;
    logic signed [31:0]     cfg_data;
    logic                   clr;
    logic                   cls_data_in;
    logic signed [31:0]     cls_i_val, cls_q_val, cls_i_pt_line, cls_q_pt_line;
    logic signed [31:0]     cls_i_vec_perp, cls_q_vec_perp;
    logic [1:0]             cls_state;
    logic                   cls_valid;
    logic                   res_valid;
    logic [2:0]             res_ch;
    logic [1:0]             res_state;
    logic                   res_timeout;
    logic                   busy;
    logic [NCH-1:0]         ch_overflow;
    logic [NCH*CW-1:0]      shot_count, one_count;

    classify_arbiter #(.NCH(NCH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk100(clk100), .rst_n(rst_n), .ch_valid(ch_valid), .ch_i(ch_i), .ch_q(ch_q),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .clr(clr),
        .cls_data_in(cls_data_in), .cls_i_val(cls_i_val), .cls_q_val(cls_q_val),
        .cls_i_pt_line(cls_i_pt_line), .cls_q_pt_line(cls_q_pt_line),
        .cls_i_vec_perp(cls_i_vec_perp), .cls_q_vec_perp(cls_q_vec_perp),
        .cls_state(cls_state), .cls_valid(cls_valid), .res_valid(res_valid), .res_ch(res_ch),
        .res_state(res_state), .res_timeout(res_timeout), .busy(busy),
        .ch_overflow(ch_overflow), .shot_count(shot_count), .one_count(one_count)
    );

    initial forever #5 clk100 = ~clk100;

    int cyc = 0;
    always @(posedge clk100) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Classifier stub: pulses cls_valid stub_lat cycles after it sees cls_data_in.
    int stub_lat = 1;
    bit stub_en = 1'b1;
    int stub_cnt = 0;
    initial begin
        cls_valid = 1'b0;
        forever begin
            @(negedge clk100);
            cls_valid = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) cls_valid = 1'b1;
            end
            if (cls_data_in && stub_en) stub_cnt = stub_lat;
        end
    end

    // Monitor: logs every issue and every result with its cycle number.
    int n_iss = 0;
    int n_res = 0;
    int iss_cyc [256];
    logic signed [31:0] iss_op [256][6];
    int res_ch_l [256];
    int res_st_l [256];
    int res_to_l [256];
    int res_cyc [256];
    initial forever begin
        @(negedge clk100);
        if (cls_data_in) begin
            iss_cyc[n_iss]   = cyc;
            iss_op[n_iss][0] = cls_i_val;
            iss_op[n_iss][1] = cls_q_val;
            iss_op[n_iss][2] = cls_i_pt_line;
            iss_op[n_iss][3] = cls_q_pt_line;
            iss_op[n_iss][4] = cls_i_vec_perp;
            iss_op[n_iss][5] = cls_q_vec_perp;
            n_iss++;
        end
        if (res_valid) begin
            res_ch_l[n_res] = int'(res_ch);
            res_st_l[n_res] = int'(res_state);
            res_to_l[n_res] = int'(res_timeout);
            res_cyc[n_res]  = cyc;
            n_res++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cfg_write(input int ch, input int sel, input int data);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = 2'(sel); cfg_data = data;
        @(negedge clk100);
        cfg_we = 1'b0;
    endtask

    // Channel k gets I = ival + k, Q = qval - k.
    task automatic strobe(input logic [NCH-1:0] mask, input int ival, input int qval, output int c0);
        c0 = cyc;
        ch_valid = mask;
        for (int k = 0; k < NCH; k++) begin
            ch_i[32*k +: 32] = ival + k;
            ch_q[32*k +: 32] = qval - k;
        end
        @(negedge clk100);
        ch_valid = '0;
    endtask

    task automatic wait_res(input string tag, input int target, input int budget);
        int c = 0;
        while (n_res < target && c < budget) begin
            @(negedge clk100);
            c++;
        end
        check(tag, n_res, target);
    endtask

    task automatic wait_res_valid(input string tag, input int budget);
        int c = 0;
        while (!res_valid && c < budget) begin
            @(negedge clk100);
            c++;
        end
        check(tag, res_valid, 1'b1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk100);
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk100);
        rst_n = 1'b1;
        @(negedge clk100);
    endtask

    initial begin
        int c0, b, ib;
        rst_n = 1'b0; ch_valid = '0; ch_i = '0; ch_q = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_sel = '0; cfg_data = '0; clr = 1'b0; cls_state = '0;
        repeat (3) @(negedge clk100);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data_in", cls_data_in, 0);
        check("rst_overflow", ch_overflow, 0);
        check("rst_shots", shot_count, 0);
        check("rst_ones", one_count, 0);
        check("rst_i_val", cls_i_val, 0);
        rst_n = 1'b1;
        @(negedge clk100);

        // Single shot on ch0; the cfg_ch=4 write must be ignored.
        cfg_write(0, 0, 0); cfg_write(0, 1, 2); cfg_write(0, 2, 0); cfg_write(0, 3, 1);
        cfg_write(4, 0, 99);
        stub_lat = 3; cls_state = 2'd2;
        ib = n_iss; b = n_res;
        strobe(4'b0001, -3, -3, c0);
        wait_res("ss_wait", b + 1, 50);
        repeat (2) @(negedge clk100);
        check("ss_issues", n_iss - ib, 1);
        check("ss_i", iss_op[ib][0], -3);
        check("ss_q", iss_op[ib][1], -3);
        check("ss_ipt", iss_op[ib][2], 0);
        check("ss_qpt", iss_op[ib][3], 2);
        check("ss_ivec", iss_op[ib][4], 0);
        check("ss_qvec", iss_op[ib][5], 1);
        check("ss_issue_cyc", iss_cyc[ib] - c0, 2);
        check("ss_res_lat", res_cyc[b] - iss_cyc[ib], 4);
        check("ss_ch", res_ch_l[b], 0);
        check("ss_state", res_st_l[b], 2);
        check("ss_to", res_to_l[b], 0);
        check("ss_shot0", shot_count[0 +: CW], 1);
        check("ss_one0", one_count[0 +: CW], 0);

        // Round robin from reset: simultaneous burst, ch2 alone, then a second burst.
        do_reset();
        stub_lat = 1; cls_state = 2'd1;
        ib = n_iss; b = n_res;
        strobe(4'b1111, 10, 0, c0);
        wait_res("rr1_wait", b + 4, 100);
        for (int k = 0; k < 4; k++) begin
            check("rr1_ch", res_ch_l[b + k], k);
            check("rr1_i", iss_op[ib + k][0], 10 + k);
        end
        check("rr1_interval", iss_cyc[ib + 1] - iss_cyc[ib], 3);
        b = n_res; ib = n_iss;
        strobe(4'b0100, 20, 0, c0);
        wait_res("rr2_wait", b + 1, 50);
        check("rr2_ch", res_ch_l[b], 2);
        check("rr2_i", iss_op[ib][0], 22);
        b = n_res;
        strobe(4'b1111, 30, 0, c0);
        wait_res("rr3_wait", b + 4, 100);
        check("rr3_ch0", res_ch_l[b], 3);
        check("rr3_ch1", res_ch_l[b + 1], 0);
        check("rr3_ch2", res_ch_l[b + 2], 1);
        check("rr3_ch3", res_ch_l[b + 3], 2);

        // Overflow: two ch1 strobes while ch0 waits; the second is dropped.
        @(negedge clk100);
        pulse_clr();
        stub_lat = 8;
        b = n_res; ib = n_iss;
        strobe(4'b0001, 1, 0, c0);
        repeat (2) @(negedge clk100);
        strobe(4'b0010, 100, 0, c0);
        strobe(4'b0010, 200, 0, c0);
        wait_res("ova_wait", b + 2, 100);
        repeat (2) @(negedge clk100);
        check("ova_flag", ch_overflow, 4'b0010);
        check("ova_ch0", res_ch_l[b], 0);
        check("ova_ch1", res_ch_l[b + 1], 1);
        check("ova_kept", iss_op[ib + 1][0], 101);
        check("ova_shot1", shot_count[CW +: CW], 1);

        // A ch1 strobe on the cycle ch1 is granted is kept without overflow.
        pulse_clr();
        b = n_res; ib = n_iss;
        strobe(4'b0001, 2, 0, c0);
        repeat (2) @(negedge clk100);
        strobe(4'b0010, 300, 0, c0);
        wait_res_valid("ovb_sync", 50);
        ch_valid = 4'b0010;
        ch_i[32 +: 32] = 401;
        @(negedge clk100);
        ch_valid = '0;
        wait_res("ovb_wait", b + 3, 100);
        repeat (2) @(negedge clk100);
        check("ovb_flag", ch_overflow, 4'b0000);
        check("ovb_first", iss_op[ib + 1][0], 301);
        check("ovb_second", iss_op[ib + 2][0], 401);
        check("ovb_ch", res_ch_l[b + 2], 1);
        check("ovb_shot1", shot_count[CW +: CW], 2);

        // Timeout: one ISSUE cycle, 64 WAIT cycles, then the aborted result.
        pulse_clr();
        stub_en = 1'b0; cls_state = 2'd1;
        b = n_res; ib = n_iss;
        strobe(4'b1000, 5, 0, c0);
        wait_res("to_wait", b + 1, 200);
        repeat (2) @(negedge clk100);
        check("to_flag", res_to_l[b], 1);
        check("to_state", res_st_l[b], 0);
        check("to_ch", res_ch_l[b], 3);
        check("to_lat", res_cyc[b] - iss_cyc[ib], 65);
        check("to_shot3", shot_count[3*CW +: CW], 0);
        check("to_one3", one_count[3*CW +: CW], 0);
        stub_en = 1'b1;

        // Saturation at 15 with CW=4, then clr coinciding with a res_valid.
        pulse_clr();
        stub_lat = 1; cls_state = 2'd1;
        for (int n = 0; n < 20; n++) begin
            b = n_res;
            strobe(4'b0001, n, 0, c0);
            wait_res("sat_wait", b + 1, 50);
        end
        repeat (2) @(negedge clk100);
        check("sat_one0", one_count[0 +: CW], 15);
        check("sat_shot0", shot_count[0 +: CW], 15);
        pulse_clr();
        b = n_res;
        strobe(4'b0001, 7, 0, c0);
        wait_res("clr_pre_wait", b + 1, 50);
        repeat (2) @(negedge clk100);
        check("clr_pre_shot0", shot_count[0 +: CW], 1);
        strobe(4'b0001, 8, 0, c0);
        wait_res_valid("clr_sync", 50);
        clr = 1'b1;
        @(negedge clk100);
        clr = 1'b0;
        @(negedge clk100);
        check("clr_shot0", shot_count[0 +: CW], 0);
        check("clr_one0", one_count[0 +: CW], 0);

        // Reset in WAIT: the late cls_valid must not produce a result.
        b = n_res;
        strobe(4'b0010, 9, 0, c0);
        wait_res("mid_pre_wait", b + 1, 50);
        repeat (2) @(negedge clk100);
        check("mid_pre_shot1", shot_count[CW +: CW], 1);
        stub_lat = 10;
        b = n_res;
        strobe(4'b0100, 11, 0, c0);
        repeat (4) @(negedge clk100);
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk100);
        rst_n = 1'b1;
        repeat (20) @(negedge clk100);
        check("mid_no_result", n_res - b, 0);
        check("mid_busy", busy, 0);
        check("mid_shots", shot_count, 0);
        check("mid_ones", one_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
